hex_scroll_marquee: RTL and testbench

HEX_SCROLL_MARQUEE -- requirements
Module: hex_scroll_marquee

---
 rtl/hex_marquee_pkg.sv | 35 +++
 rtl/hex_char_decoder.sv | 27 ++
 rtl/hex_scroll_marquee.sv | 143 ++++++++++++++
 tb/tb_hex_scroll_marquee.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_marquee_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_marquee_pkg                                                      |
// | Character codes, segment patterns and FSM states for the marquee.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package hex_marquee_pkg;

  typedef enum logic [2:0] {
    CH_D      = 3'd0,
    CH_E      = 3'd1,
    CH_ONE    = 3'd2,
    CH_ZERO   = 3'd3,
    CH_TWO    = 3'd4,
    CH_BLANK5 = 3'd5,
    CH_BLANK6 = 3'd6,
    CH_BLANK7 = 3'd7
  } char_code_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] c_SEG_D    = 7'b0100001;
  localparam logic [6:0] c_SEG_E    = 7'b0000110;
  localparam logic [6:0] c_SEG_ONE  = 7'b1111001;
  localparam logic [6:0] c_SEG_ZERO = 7'b1000000;
  localparam logic [6:0] c_SEG_TWO  = 7'b0100100;
  localparam logic [6:0] BLANK_SEG  = 7'h7F;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hex_char_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_char_decoder                                                     |
// | Combinational 3-bit character code to active-low 7-segment pattern. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hex_char_decoder
  import hex_marquee_pkg::*;
(
  input  char_code_e i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = BLANK_SEG;
    case (i_code)
      CH_D:    o_seg = c_SEG_D;
      CH_E:    o_seg = c_SEG_E;
      CH_ONE:  o_seg = c_SEG_ONE;
      CH_ZERO: o_seg = c_SEG_ZERO;
      CH_TWO:  o_seg = c_SEG_TWO;
      default: o_seg = BLANK_SEG;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hex_scroll_marquee.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_scroll_marquee                                                   |
// | Circular message scroller over NUM_DISP seven-segment displays.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module hex_scroll_marquee
  import hex_marquee_pkg::*;
#(
  parameter int NUM_DISP = 8,
  parameter int MSG_LEN  = 8,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             dir,
  input  logic                             step_btn,
  input  logic                             clr,
  input  logic [MSG_LEN-1:0][2:0]          msg,
  output logic [NUM_DISP-1:0][6:0]         hex_disp,
  output logic [$clog2(MSG_LEN+1)-1:0]     pos,
  output logic                             step_pulse
);

  localparam int c_POS_W   = $clog2(MSG_LEN + 1);
  localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_IDX_W   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
  localparam logic [c_POS_W-1:0]   c_POS_LAST   = c_POS_W'(MSG_LEN - 1);

  state_e                      r_state;
  logic [c_PRESC_W-1:0]        r_presc;
  logic [c_POS_W-1:0]          r_pos;
  logic                        r_step_pulse;
  logic [NUM_DISP-1:0][6:0]    r_hex;

  logic                        r_sync1;
  logic                        r_sync2;
  logic                        r_btn_prev;

  logic                        w_btn_fall;
  logic                        w_tick;
  logic                        w_step;
  logic                        w_to_blank;
  logic [c_POS_W-1:0]          w_pos_nxt;
  logic [NUM_DISP-1:0][6:0]    w_seg;

  // Button idles high, so the synchroniser resets high to avoid a false press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_btn_prev <= 1'b1;
    end else begin
      r_sync1    <= step_btn;
      r_sync2    <= r_sync1;
      r_btn_prev <= r_sync2;
    end
  end

  assign w_btn_fall = r_btn_prev & ~r_sync2;

  assign w_tick     = (r_state == ST_RUN) && (r_presc == c_PRESC_LAST);
  assign w_step     = !clr && (w_tick || ((r_state == ST_HOLD) && w_btn_fall));
  assign w_to_blank = clr || ((r_state == ST_BLANK) && !en);

  always_comb begin
    w_pos_nxt = r_pos;
    if (dir) begin
      w_pos_nxt = (r_pos == '0) ? c_POS_LAST : r_pos - 1'b1;
    end else begin
      w_pos_nxt = (r_pos == c_POS_LAST) ? '0 : r_pos + 1'b1;
    end
  end

  // Display k (k = NUM_DISP-1 is leftmost) shows msg[(pos + NUM_DISP-1-k) mod MSG_LEN]
  for (genvar k = 0; k < NUM_DISP; k++) begin : g_disp
    logic [5:0]         w_sum;
    logic [c_IDX_W-1:0] w_idx;

    assign w_sum = 6'(r_pos) + 6'(NUM_DISP - 1 - k);
    assign w_idx = c_IDX_W'(w_sum % 6'(MSG_LEN));

    hex_char_decoder u_dec (
      .i_code (char_code_e'(msg[w_idx])),
      .o_seg  (w_seg[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_BLANK;
      r_presc      <= '0;
      r_pos        <= '0;
      r_step_pulse <= 1'b0;
      r_hex        <= {NUM_DISP{BLANK_SEG}};
    end else begin
      r_step_pulse <= w_step;
      r_hex        <= w_to_blank ? {NUM_DISP{BLANK_SEG}} : w_seg;
      if (clr) begin
        r_state <= ST_BLANK;
        r_presc <= '0;
        r_pos   <= '0;
      end else begin
        if (w_step) begin
          r_pos <= w_pos_nxt;
        end
        case (r_state)
          ST_BLANK: begin
            r_presc <= '0;
            r_pos   <= '0;
            if (en) begin
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            // A terminal count coinciding with en falling still steps, then holds
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (!en) begin
              r_state <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (en) begin
              r_state <= ST_RUN;
            end
          end
          default: begin
            r_state <= ST_BLANK;
          end
        endcase
      end
    end
  end

  assign hex_disp   = r_hex;
  assign pos        = r_pos;
  assign step_pulse = r_step_pulse;

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_marquee.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hex_scroll_marquee                                                |
// | Self-checking bench: 8-char and 3-char marquees against a model.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_hex_scroll_marquee;

  localparam int TICK = 4;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic en       = 1'b0;
  logic dir      = 1'b0;
  logic step_btn = 1'b1;
  logic clr      = 1'b0;

  logic [7:0][2:0] msg8;
  logic [2:0][2:0] msg3;
  logic [7:0][6:0] hex8;
  logic [7:0][6:0] hex3;
  logic [3:0]      pos8;
  logic [1:0]      pos3;
  logic            pulse8;
  logic            pulse3;

  assign msg8 = {3'd5, 3'd5, 3'd5, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};
  assign msg3 = {3'd2, 3'd1, 3'd0};

  always #5 clk = ~clk;

  hex_scroll_marquee #(.NUM_DISP(8), .MSG_LEN(8), .TICK_DIV(TICK)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .step_btn(step_btn), .clr(clr),
    .msg(msg8), .hex_disp(hex8), .pos(pos8), .step_pulse(pulse8)
  );

  hex_scroll_marquee #(.NUM_DISP(8), .MSG_LEN(3), .TICK_DIV(TICK)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .step_btn(step_btn), .clr(clr),
    .msg(msg3), .hex_disp(hex3), .pos(pos3), .step_pulse(pulse3)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int code);
    case (code)
      0:       return 7'b0100001;
      1:       return 7'b0000110;
      2:       return 7'b1111001;
      3:       return 7'b1000000;
      4:       return 7'b0100100;
      default: return 7'h7F;
    endcase
  endfunction

  // Model: mode 0=blank, 1=run, 2=hold; index 0 is the 8-char DUT, 1 the 3-char DUT
  int              m_len  [2] = '{8, 3};
  int              m_code [2][8];
  int              m_mode [2];
  int              m_pos  [2];
  int              m_presc[2];
  bit              m_pulse[2];
  logic [7:0][6:0] m_hex  [2];
  bit              h0, h1, h2;

  task automatic reset_model();
    h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_mode[d]  = 0;
      m_pos[d]   = 0;
      m_presc[d] = 0;
      m_pulse[d] = 1'b0;
      m_hex[d]   = {8{7'h7F}};
    end
  endtask

  task automatic model_step();
    bit fall, tc, stp, blank_next;
    cyc++;
    if (!rst_n) begin
      reset_model();
    end else begin
      // a press seen by the model three samples ago (1 then 0) becomes a step now
      fall = h2 && !h1;
      h2 = h1; h1 = h0; h0 = step_btn;
      for (int d = 0; d < 2; d++) begin
        tc         = (m_mode[d] == 1) && (m_presc[d] == TICK - 1);
        stp        = !clr && (tc || (m_mode[d] == 2 && fall));
        blank_next = clr || (m_mode[d] == 0 && !en);
        for (int k = 0; k < 8; k++) begin
          m_hex[d][k] = blank_next ? 7'h7F : seg_of(m_code[d][(m_pos[d] + 7 - k) % m_len[d]]);
        end
        m_pulse[d] = stp;
        if (clr) begin
          m_mode[d] = 0; m_pos[d] = 0; m_presc[d] = 0;
        end else begin
          if (stp) begin
            m_pos[d] = dir ? (m_pos[d] + m_len[d] - 1) % m_len[d] : (m_pos[d] + 1) % m_len[d];
          end
          case (m_mode[d])
            0: begin m_presc[d] = 0; if (en) m_mode[d] = 1; end
            1: begin m_presc[d] = (m_presc[d] + 1) % TICK; if (!en) m_mode[d] = 2; end
            default: if (en) m_mode[d] = 1;
          endcase
        end
      end
    end
  endtask

  initial begin
    m_code[0] = '{0, 1, 2, 4, 5, 5, 5, 5};
    m_code[1] = '{0, 1, 2, 0, 0, 0, 0, 0};
    reset_model();
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("pos8",   64'(pos8),   64'(m_pos[0]));
      check("pulse8", 64'(pulse8), 64'(m_pulse[0]));
      check("hex8",   64'(hex8),   64'(m_hex[0]));
      check("pos3",   64'(pos3),   64'(m_pos[1]));
      check("pulse3", 64'(pulse3), 64'(m_pulse[1]));
      check("hex3",   64'(hex3),   64'(m_hex[1]));
    end
  end

  task automatic wait_pulse(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (pulse8) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("pulse_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int t, prev, n_p, first;
    bit found;

    repeat (3) @(negedge clk);
    checking = 1'b1;
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_hex8", 64'(hex8), 64'({8{7'h7F}}));
    check("rst_pos8", 64'(pos8), 64'd0);
    check("rst_hex3", 64'(hex3), 64'({8{7'h7F}}));
    check("rst_pos3", 64'(pos3), 64'd0);

    #1 en = 1'b1;
    @(negedge clk);
    check("short_msg", 64'(hex3),
          64'({7'h21, 7'h06, 7'h79, 7'h21, 7'h06, 7'h79, 7'h21, 7'h06}));
    check("left_d", 64'(hex8[7]), 64'h21);

    prev = -1;
    for (int i = 1; i <= 8; i++) begin
      wait_pulse(8, t);
      check("auto_pos", 64'(pos8), 64'(i % 8));
      if (prev >= 0) check("auto_period", 64'(t - prev), 64'd4);
      prev = t;
      if (i == 1) begin
        @(negedge clk);
        check("left_E", 64'(hex8[7]), 64'h06);
      end
    end

    #1 dir = 1'b1;
    wait_pulse(8, t);
    check("rwrap_7", 64'(pos8), 64'd7);
    wait_pulse(8, t);
    check("rwrap_6", 64'(pos8), 64'd6);

    #1 en = 1'b0;
    repeat (3) @(negedge clk);
    #1 step_btn = 1'b0;
    n_p   = 0;
    first = -1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (pulse8) begin
        n_p++;
        if (first < 0) first = j;
      end
      if (j == 5) #1 step_btn = 1'b1;
    end
    check("btn_count",   64'(n_p),   64'd1);
    check("btn_latency", 64'(first), 64'd3);
    check("btn_pos",     64'(pos8),  64'd5);

    #1 dir = 1'b0; en = 1'b1;
    found = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (m_mode[0] == 1 && m_presc[0] == TICK - 1) begin
        found = 1'b1;
        break;
      end
    end
    check("tc_found", 64'(found), 64'd1);
    #1 clr = 1'b1;
    @(negedge clk);
    check("clr_pulse", 64'(pulse8), 64'd0);
    check("clr_pos",   64'(pos8),   64'd0);
    check("clr_hex",   64'(hex8),   64'({8{7'h7F}}));
    check("clr_pos3",  64'(pos3),   64'd0);
    #1 clr = 1'b0;
    repeat (9) @(negedge clk);

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 en = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rel_hex", 64'(hex8), 64'({8{7'h7F}}));
    check("rel_pos", 64'(pos8), 64'd0);
    #1 en = 1'b1; dir = 1'b1;
    repeat (14) @(negedge clk);

    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
